// File: rtl/ddc_pkg.sv
`default_nettype none
// ddc_pkg: shared sequencer state encoding, work-mode constants and the
// mode-to-filter decode used by both the sequencer and the datapath mux.  (rev 1.0)
package ddc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CLR   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_RUN   = 3'd4
  } seq_state_e;

  localparam logic [7:0] MODE_1M_A = 8'h01;
  localparam logic [7:0] MODE_1M_B = 8'h03;

  // 1 selects the 1 MHz decimating FIR, 0 the 20 MHz one.
  function automatic logic mode_to_fir_sel(input logic [7:0] mode);
    return (mode == MODE_1M_A) || (mode == MODE_1M_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddc_seq_cnt.sv
`default_nettype none
// ddc_seq_cnt: loadable saturating up-counter with clear and terminal compare,
// shared by the WAIT, CLR and FLUSH phases of ddc_seq_ctrl.  (rev 1.0)
module ddc_seq_cnt #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] term_val,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q == term_val);

endmodule
`default_nettype wire

// File: rtl/ddc_seq_ctrl.sv
`default_nettype none
// ddc_seq_ctrl: PRI-synchronous DDC filter-bank sequencer (mode latch, delayed sclr
// window, rdy flush, output qualify). Optional DDC_SEQ_OVR_EN adds a PRI-overrun counter.  (rev 1.0)
module ddc_seq_ctrl
  import ddc_pkg::*;
#(
  parameter int SCLR_DLY     = 300,
  parameter int SCLR_LEN_20M = 51,
  parameter int SCLR_LEN_1M  = 1,
  parameter int FLUSH_20M    = 32,
  parameter int FLUSH_1M     = 2,
  parameter int CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pri,
  input  logic [7:0]  work_mode_ifm,
  input  logic        rdy_20m,
  input  logic        rdy_1m,
  output logic        fir_sel,
  output logic [7:0]  mode_lat,
  output logic        sclr_20m,
  output logic        sclr_1m,
  output logic        out_valid,
  output logic [2:0]  state_o,
  output logic [15:0] pri_ovr_cnt
);

  localparam logic [CNT_W-1:0] DLY_TERM    = CNT_W'(SCLR_DLY - 1);
  localparam logic [CNT_W-1:0] LEN_TERM_20 = CNT_W'(SCLR_LEN_20M - 1);
  localparam logic [CNT_W-1:0] LEN_TERM_1  = CNT_W'(SCLR_LEN_1M - 1);
  localparam logic [CNT_W-1:0] FL_TERM_20  = CNT_W'((FLUSH_20M == 0) ? 0 : FLUSH_20M - 1);
  localparam logic [CNT_W-1:0] FL_TERM_1   = CNT_W'((FLUSH_1M == 0) ? 0 : FLUSH_1M - 1);

  seq_state_e       state_q, state_d;
  logic             fir_sel_q, fir_sel_d;
  logic [7:0]       mode_lat_q, mode_lat_d;
  logic             sclr_20m_q, sclr_20m_d;
  logic             sclr_1m_q, sclr_1m_d;
  logic             out_valid_q, out_valid_d;
  logic             cnt_clr, cnt_en, cnt_at_term;
  logic [CNT_W-1:0] cnt_term;
  logic             rdy_sel;
  logic             flush_none;

  assign rdy_sel    = fir_sel_q ? rdy_1m : rdy_20m;
  assign flush_none = fir_sel_q ? (FLUSH_1M == 0) : (FLUSH_20M == 0);

  always_comb begin
    state_d    = state_q;
    fir_sel_d  = fir_sel_q;
    mode_lat_d = mode_lat_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cnt_term   = '0;
    unique case (state_q)
      ST_WAIT: begin
        cnt_en   = 1'b1;
        cnt_term = DLY_TERM;
        if (cnt_at_term) begin
          state_d = ST_CLR;
          cnt_clr = 1'b1;
        end
      end
      ST_CLR: begin
        cnt_en   = 1'b1;
        cnt_term = fir_sel_q ? LEN_TERM_1 : LEN_TERM_20;
        if (cnt_at_term) begin
          state_d = flush_none ? ST_RUN : ST_FLUSH;
          cnt_clr = 1'b1;
        end
      end
      ST_FLUSH: begin
        cnt_term = fir_sel_q ? FL_TERM_1 : FL_TERM_20;
        if (rdy_sel) begin
          cnt_en = 1'b1;
          if (cnt_at_term) begin
            state_d = ST_RUN;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_IDLE, ST_RUN: ;
      default: state_d = ST_IDLE;
    endcase
    // A PRI sample restarts the sequence from any state.
    if (pri) begin
      state_d    = ST_WAIT;
      cnt_clr    = 1'b1;
      mode_lat_d = work_mode_ifm;
      fir_sel_d  = mode_to_fir_sel(work_mode_ifm);
    end
  end

  // Unselected FIR stays cleared outside IDLE; the selected one clears only in CLR.
  always_comb begin
    sclr_20m_d  = 1'b0;
    sclr_1m_d   = 1'b0;
    out_valid_d = 1'b0;
    if (state_q != ST_IDLE) begin
      sclr_20m_d = fir_sel_q ? 1'b1 : (state_q == ST_CLR);
      sclr_1m_d  = fir_sel_q ? (state_q == ST_CLR) : 1'b1;
    end
    if ((state_q == ST_RUN) && rdy_sel && !pri) begin
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fir_sel_q   <= 1'b0;
      mode_lat_q  <= 8'h00;
      sclr_20m_q  <= 1'b1;
      sclr_1m_q   <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fir_sel_q   <= fir_sel_d;
      mode_lat_q  <= mode_lat_d;
      sclr_20m_q  <= sclr_20m_d;
      sclr_1m_q   <= sclr_1m_d;
      out_valid_q <= out_valid_d;
    end
  end

  ddc_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .load    (1'b0),
    .en      (cnt_en),
    .load_val('0),
    .term_val(cnt_term),
    .at_term (cnt_at_term)
  );

`ifdef DDC_SEQ_OVR_EN
  logic        pri_prev_q;
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  // Only a fresh PRI that aborts an in-flight sequence counts as an overrun.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (pri && !pri_prev_q && (ovr_cnt_q != 16'hFFFF) &&
        ((state_q == ST_WAIT) || (state_q == ST_CLR) || (state_q == ST_FLUSH))) begin
      ovr_cnt_d = ovr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_prev_q <= 1'b0;
      ovr_cnt_q  <= 16'h0000;
    end else begin
      pri_prev_q <= pri;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign pri_ovr_cnt = ovr_cnt_q;
`else
  assign pri_ovr_cnt = 16'h0000;
`endif

  assign fir_sel   = fir_sel_q;
  assign mode_lat  = mode_lat_q;
  assign sclr_20m  = sclr_20m_q;
  assign sclr_1m   = sclr_1m_q;
  assign out_valid = out_valid_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ddc_seq_ctrl.sv
`default_nettype none
// tb_ddc_seq_ctrl: directed self-checking bench for ddc_seq_ctrl with hand-computed
// cycle positions relative to each PRI sample edge.  (rev 1.0)
module tb_ddc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pri;
  logic [7:0]  work_mode_ifm;
  logic        rdy_20m;
  logic        rdy_1m;
  logic        fir_sel;
  logic [7:0]  mode_lat;
  logic        sclr_20m;
  logic        sclr_1m;
  logic        out_valid;
  logic [2:0]  state_o;
  logic [15:0] pri_ovr_cnt;

  int n_total = 0;
  int n_bad   = 0;
  logic ov_seen;

`ifdef DDC_SEQ_OVR_EN
  localparam int OVR_ON = 1;
`else
  localparam int OVR_ON = 0;
`endif

  always #5 clk = ~clk;

  ddc_seq_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pri          (pri),
    .work_mode_ifm(work_mode_ifm),
    .rdy_20m      (rdy_20m),
    .rdy_1m       (rdy_1m),
    .fir_sel      (fir_sel),
    .mode_lat     (mode_lat),
    .sclr_20m     (sclr_20m),
    .sclr_1m      (sclr_1m),
    .out_valid    (out_valid),
    .state_o      (state_o),
    .pri_ovr_cnt  (pri_ovr_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; outputs sampled 1 ns later, inputs changed at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; pri = 1'b1; work_mode_ifm = 8'h03; rdy_20m = 1'b0; rdy_1m = 1'b0;

    // Reset held 5 cycles, with pri asserted to show reset dominates.
    adv(5);
    check_eq("rst_sclr20", sclr_20m, 1);
    check_eq("rst_sclr1", sclr_1m, 1);
    check_eq("rst_oval", out_valid, 0);
    check_eq("rst_state", state_o, 0);
    check_eq("rst_firsel", fir_sel, 0);
    check_eq("rst_mode", mode_lat, 0);
    check_eq("rst_ovr", pri_ovr_cnt, 0);
    rst_n = 1'b1; pri = 1'b0; work_mode_ifm = 8'h00;
    tick();
    check_eq("idle_sclr20", sclr_20m, 0);
    check_eq("idle_sclr1", sclr_1m, 0);
    check_eq("idle_state", state_o, 0);
    adv(3);

    // 20 MHz path from IDLE.
    work_mode_ifm = 8'h00; pri = 1'b1;
    tick(); pri = 1'b0;                              // t0
    check_eq("m0_state_wait", state_o, 1);
    check_eq("m0_firsel", fir_sel, 0);
    check_eq("m0_mode", mode_lat, 8'h00);
    tick();                                          // t0+1
    check_eq("m0_sclr1_t1", sclr_1m, 1);
    check_eq("m0_sclr20_t1", sclr_20m, 0);
    adv(299);                                        // t0+300
    check_eq("m0_sclr20_t300", sclr_20m, 0);
    check_eq("m0_state_clr", state_o, 2);
    tick();                                          // t0+301
    check_eq("m0_sclr20_t301", sclr_20m, 1);
    adv(50);                                         // t0+351
    check_eq("m0_sclr20_t351", sclr_20m, 1);
    check_eq("m0_state_flush", state_o, 3);
    tick();                                          // t0+352
    check_eq("m0_sclr20_t352", sclr_20m, 0);
    check_eq("m0_sclr1_t352", sclr_1m, 1);
    ov_seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rdy_20m = 1'b1; rdy_1m = (i % 4 == 0);
      tick(); ov_seen |= out_valid;
      rdy_20m = 1'b0; rdy_1m = 1'b0;
      tick(); ov_seen |= out_valid;
    end
    check_eq("m0_flush_blank", ov_seen, 0);
    check_eq("m0_state_run", state_o, 4);
    rdy_20m = 1'b1;
    tick(); rdy_20m = 1'b0;
    check_eq("m0_strobe33", out_valid, 1);
    tick();
    check_eq("m0_oval_drop", out_valid, 0);
    rdy_1m = 1'b1;
    tick(); rdy_1m = 1'b0;
    check_eq("m0_unsel_rdy", out_valid, 0);

    // In RUN: pri with rdy_20m, switching to the 1 MHz path.
    work_mode_ifm = 8'h03; pri = 1'b1; rdy_20m = 1'b1;
    tick(); pri = 1'b0; rdy_20m = 1'b0;              // t0
    check_eq("m3_pri_wins", out_valid, 0);
    check_eq("m3_state_wait", state_o, 1);
    check_eq("m3_firsel", fir_sel, 1);
    check_eq("m3_mode", mode_lat, 8'h03);
    tick();                                          // t0+1
    check_eq("m3_sclr20_t1", sclr_20m, 1);
    check_eq("m3_sclr1_t1", sclr_1m, 0);
    adv(299);                                        // t0+300
    check_eq("m3_sclr1_t300", sclr_1m, 0);
    tick();                                          // t0+301
    check_eq("m3_sclr1_t301", sclr_1m, 1);
    check_eq("m3_state_flush", state_o, 3);
    tick();                                          // t0+302
    check_eq("m3_sclr1_t302", sclr_1m, 0);
    check_eq("m3_sclr20_t302", sclr_20m, 1);
    ov_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rdy_20m = 1'b1; tick(); ov_seen |= out_valid; rdy_20m = 1'b0;
      rdy_1m  = 1'b1; tick(); ov_seen |= out_valid; rdy_1m  = 1'b0;
      tick(); ov_seen |= out_valid;
    end
    check_eq("m3_flush_blank", ov_seen, 0);
    check_eq("m3_state_run", state_o, 4);
    check_eq("m3_ovr_from_run", pri_ovr_cnt, 0);
    rdy_1m = 1'b1;
    tick(); rdy_1m = 1'b0;
    check_eq("m3_strobe3", out_valid, 1);
    tick();

    // Abort at t0+320 with a mode change back to the 20 MHz path.
    work_mode_ifm = 8'h03; pri = 1'b1;
    tick(); pri = 1'b0;                              // t0
    adv(319);                                        // t0+319
    check_eq("ab_state_pre", state_o, 3);
    work_mode_ifm = 8'h00; pri = 1'b1;
    tick(); pri = 1'b0;                              // t1 = t0+320
    check_eq("ab_state_wait", state_o, 1);
    check_eq("ab_firsel", fir_sel, 0);
    check_eq("ab_mode", mode_lat, 8'h00);
    check_eq("ab_ovr", pri_ovr_cnt, OVR_ON);
    tick();                                          // t1+1
    check_eq("ab_sclr20_t1", sclr_20m, 0);
    check_eq("ab_sclr1_t1", sclr_1m, 1);
    adv(299);                                        // t1+300
    check_eq("ab_sclr20_t300", sclr_20m, 0);
    tick();                                          // t1+301
    check_eq("ab_sclr20_t301", sclr_20m, 1);

    // pri held 4 cycles mid-CLR: one overrun, window timed from the last sample.
    adv(9);
    pri = 1'b1;
    adv(4); pri = 1'b0;                              // tL
    check_eq("hold_state", state_o, 1);
    check_eq("hold_ovr", pri_ovr_cnt, 2 * OVR_ON);
    tick();                                          // tL+1
    check_eq("hold_sclr20_t1", sclr_20m, 0);
    adv(299);                                        // tL+300
    check_eq("hold_sclr20_t300", sclr_20m, 0);
    check_eq("hold_state_clr", state_o, 2);
    tick();                                          // tL+301
    check_eq("hold_sclr20_t301", sclr_20m, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
